// File: rtl/arb_fifo.sv
// arb_fifo: buffering stage behind the two-slave arbiter, with first-word fall-through through a registered output stage.
// Optional sticky overflow and source-interleave error flags are enabled with `define ARB_FIFO_ERR_EN.
module arb_fifo #(
  parameter int DW       = 32,
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  input  logic [1:0]    wr_mode,
  input  logic [7:0]    wr_proc_val,
  input  logic          wr_src,
  output logic          fifo_full,
  output logic          fifo_afull,
  output logic          fifo_empty,
  output logic [AW:0]   fill_cnt,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic [1:0]    rd_mode,
  output logic [7:0]    rd_proc_val,
  output logic          rd_src
`ifdef ARB_FIFO_ERR_EN
  ,
  output logic          ovf_err,
  output logic          src_err
`endif
);

  localparam int          WW          = DW + 11;
  localparam logic [AW:0] LP_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_AFULL_TH = (AW+1)'(AFULL_TH);

  typedef struct packed {
    logic          src;
    logic [7:0]    proc_val;
    logic [1:0]    mode;
    logic [DW-1:0] data;
  } word_t;

  word_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_fill_cnt;
  logic          r_full;
  logic          r_afull;
  logic          r_empty;
  logic          r_rd_valid;
  word_t         r_rd_word;

  logic          w_wr_accept;
  logic          w_load;
  logic          w_rd_valid_nxt;
  logic [AW:0]   w_fill_nxt;
  word_t         w_wr_word;

  // Full comes from the registered count, so a read in this cycle never frees room for a write in this cycle.
  assign w_wr_accept = wr_valid && !r_full;
  assign w_load      = (r_fill_cnt != '0) && (!r_rd_valid || rd_ready);
  assign w_wr_word   = '{src: wr_src, proc_val: wr_proc_val, mode: wr_mode, data: wr_data};

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_fill_nxt     = r_fill_cnt;
    w_rd_valid_nxt = r_rd_valid;
    if (w_wr_accept && !w_load) w_fill_nxt = r_fill_cnt + (AW+1)'(1);
    if (!w_wr_accept && w_load) w_fill_nxt = r_fill_cnt - (AW+1)'(1);
    if (w_load)
      w_rd_valid_nxt = 1'b1;
    else if (rd_ready)
      w_rd_valid_nxt = 1'b0;
  end

  // NOTE: the storage array has no reset; pointers and count define which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_wr_accept) r_mem[r_wr_ptr] <= w_wr_word;
  end

  // Reset and flush share one clear path; flush discards any same-cycle write or load.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fill_cnt <= '0;
      r_full     <= 1'b0;
      r_afull    <= 1'b0;
      r_empty    <= 1'b1;
      r_rd_valid <= 1'b0;
      r_rd_word  <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_load) begin
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_rd_word <= r_mem[r_rd_ptr];
      end
      r_fill_cnt <= w_fill_nxt;
      r_full     <= (w_fill_nxt == LP_DEPTH);
      r_afull    <= (w_fill_nxt >= LP_AFULL_TH);
      r_empty    <= (w_fill_nxt == '0) && !w_rd_valid_nxt;
      r_rd_valid <= w_rd_valid_nxt;
    end
  end

  assign fifo_full   = r_full;
  assign fifo_afull  = r_afull;
  assign fifo_empty  = r_empty;
  assign fill_cnt    = r_fill_cnt;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_word.data;
  assign rd_mode     = r_rd_word.mode;
  assign rd_proc_val = r_rd_word.proc_val;
  assign rd_src      = r_rd_word.src;

`ifdef ARB_FIFO_ERR_EN
  logic       r_ovf_err;
  logic       r_src_err;
  logic       r_prev_vld;
  logic       r_prev_src;
  logic [1:0] r_prev_mode;
  logic       w_src_switch;

  // A source change while the previous non-zero mode continues means the two slaves interleaved mid-stream.
  assign w_src_switch = w_wr_accept && r_prev_vld && (wr_src != r_prev_src) &&
                        (wr_mode == r_prev_mode) && (r_prev_mode != 2'd0);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_ovf_err   <= 1'b0;
      r_src_err   <= 1'b0;
      r_prev_vld  <= 1'b0;
      r_prev_src  <= 1'b0;
      r_prev_mode <= 2'd0;
    end else begin
      if (wr_valid && r_full) r_ovf_err <= 1'b1;
      if (w_src_switch)       r_src_err <= 1'b1;
      if (w_wr_accept) begin
        r_prev_vld  <= 1'b1;
        r_prev_src  <= wr_src;
        r_prev_mode <= wr_mode;
      end
    end
  end

  assign ovf_err = r_ovf_err;
  assign src_err = r_src_err;
`endif

endmodule

// File: tb/tb_arb_fifo.sv
// Directed self-checking bench for arb_fifo (DEPTH=16): flow, fill/overflow, wrap, simultaneous, flush and reset.
// Error-flag checks are included when ARB_FIFO_ERR_EN is defined.
module tb_arb_fifo;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, wr_valid, wr_src, rd_ready;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_mode;
  logic [7:0]    wr_proc_val;
  logic          fifo_full, fifo_afull, fifo_empty, rd_valid, rd_src;
  logic [AW:0]   fill_cnt;
  logic [DW-1:0] rd_data;
  logic [1:0]    rd_mode;
  logic [7:0]    rd_proc_val;
`ifdef ARB_FIFO_ERR_EN
  logic          ovf_err, src_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arb_fifo #(.DW(DW), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_mode(wr_mode),
    .wr_proc_val(wr_proc_val), .wr_src(wr_src),
    .fifo_full(fifo_full), .fifo_afull(fifo_afull), .fifo_empty(fifo_empty),
    .fill_cnt(fill_cnt), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_mode(rd_mode), .rd_proc_val(rd_proc_val), .rd_src(rd_src)
`ifdef ARB_FIFO_ERR_EN
    , .ovf_err(ovf_err), .src_err(src_err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic v, input logic [31:0] d, input logic [1:0] m,
                          input logic [7:0] p, input logic s);
    wr_valid    = v;
    wr_data     = d;
    wr_mode     = m;
    wr_proc_val = p;
    wr_src      = s;
  endtask

  function automatic logic [42:0] rd_word();
    return {rd_src, rd_proc_val, rd_mode, rd_data};
  endfunction

  function automatic logic [42:0] fill_word(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {v[0], v[7:0], v[1:0], 32'(32'h100 + i)};
  endfunction

  function automatic logic [42:0] wrap_word(input int i);
    logic [31:0] v;
    v = 32'(i);
    return {v[0] ^ v[2], 8'(i * 7), v[1:0], 32'(32'hC000_0000 + i * 3)};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int widx;
    int ridx;
    int max_fill;
    int exp_fill;

    rst_n = 1'b0; flush = 1'b0; rd_ready = 1'b0;
    drive_wr(1'b0, 32'h0, 2'd0, 8'h0, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    check("reset_fill", fill_cnt, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_full", fifo_full, 0);
    check("reset_afull", fifo_afull, 0);
    check("reset_empty", fifo_empty, 1);
    check("reset_rd_word", rd_word(), 0);

    // Flow: three words with the master always ready.
    rd_ready = 1'b1;
    drive_wr(1'b1, 32'h11, 2'd1, 8'h01, 1'b0); tick();
    check("flow_lat_valid_lo", rd_valid, 0);
    check("flow_lat_fill", fill_cnt, 1);
    drive_wr(1'b1, 32'h22, 2'd1, 8'h02, 1'b0); tick();
    check("flow_valid", rd_valid, 1);
    check("flow_data0", rd_data, 32'h11);
    drive_wr(1'b1, 32'h33, 2'd1, 8'h03, 1'b0); tick();
    check("flow_data1", rd_data, 32'h22);
    drive_wr(1'b0, 32'h0, 2'd0, 8'h0, 1'b0); tick();
    check("flow_data2", rd_data, 32'h33);
    check("flow_fill0", fill_cnt, 0);
    tick();
    check("flow_valid_drop", rd_valid, 0);
    check("flow_empty", fifo_empty, 1);
    check("flow_hold", rd_data, 32'h33);

    // Fill: 17 writes with the master stalled.
    rd_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive_wr(1'b1, 32'(32'h100 + i), 2'(i), 8'(i), 1'(i));
      tick();
      exp_fill = (i == 0) ? 1 : i;
      check($sformatf("fill_cnt_%0d", i), fill_cnt, 64'(exp_fill));
      check($sformatf("fill_afull_%0d", i), fifo_afull, 64'(exp_fill >= 14));
    end
    check("fill_full", fifo_full, 1);
    check("fill_head_stable", rd_word(), fill_word(0));
    drive_wr(1'b1, 32'hBAD, 2'd3, 8'hFF, 1'b1); tick();
    check("ovf_fill", fill_cnt, 16);
    check("ovf_head_stable", rd_word(), fill_word(0));
`ifdef ARB_FIFO_ERR_EN
    check("ovf_err_set", ovf_err, 1);
`endif

    // Simultaneous read and write at full: the write is still dropped.
    rd_ready = 1'b1;
    drive_wr(1'b1, 32'hDEAD, 2'd2, 8'hEE, 1'b0); tick();
    drive_wr(1'b0, 32'h0, 2'd0, 8'h0, 1'b0);
    check("simul_fill", fill_cnt, 15);
    check("simul_full", fifo_full, 0);
    for (int i = 1; i < 17; i++) begin
      check($sformatf("drain_valid_%0d", i), rd_valid, 1);
      check($sformatf("drain_word_%0d", i), rd_word(), fill_word(i));
      tick();
    end
    check("drain_valid_end", rd_valid, 0);
    check("drain_empty", fifo_empty, 1);
    check("drain_fill", fill_cnt, 0);

    // Wrap: 40 words written every other cycle, master ready on alternate cycles.
    widx = 0; ridx = 0; max_fill = 0;
    for (int c = 0; c < 300 && ridx < 40; c++) begin
      if (int'(fill_cnt) > max_fill) max_fill = int'(fill_cnt);
      rd_ready = (c % 2 == 0);
      if (rd_valid && rd_ready) begin
        check($sformatf("wrap_word_%0d", ridx), rd_word(), wrap_word(ridx));
        ridx++;
      end
      if (c % 2 == 0 && widx < 40) begin
        drive_wr(1'b1, 32'(32'hC000_0000 + widx * 3), 2'(widx), 8'(widx * 7),
                 1'(widx) ^ 1'(widx >> 2));
        widx++;
      end else begin
        drive_wr(1'b0, 32'h0, 2'd0, 8'h0, 1'b0);
      end
      tick();
    end
    drive_wr(1'b0, 32'h0, 2'd0, 8'h0, 1'b0);
    check("wrap_count", ridx, 40);
    check("wrap_fill_bound", max_fill <= 16, 1);
    check("wrap_end_valid", rd_valid, 0);
    check("wrap_end_fill", fill_cnt, 0);

    // Flush with a concurrent write.
    rd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive_wr(1'b1, 32'(32'h500 + k), 2'd1, 8'(k), 1'b0);
      tick();
    end
    check("preflush_fill", fill_cnt, 4);
    check("preflush_valid", rd_valid, 1);
    flush = 1'b1;
    drive_wr(1'b1, 32'h5FF, 2'd2, 8'h55, 1'b1); tick();
    flush = 1'b0;
    drive_wr(1'b0, 32'h0, 2'd0, 8'h0, 1'b0);
    check("flush_fill", fill_cnt, 0);
    check("flush_valid", rd_valid, 0);
    check("flush_empty", fifo_empty, 1);
`ifdef ARB_FIFO_ERR_EN
    check("flush_ovf_clr", ovf_err, 0);
`endif
    tick(); tick();
    check("flush_discard_valid", rd_valid, 0);
    check("flush_discard_fill", fill_cnt, 0);

    // Reset in the middle of a stalled burst.
    for (int k = 0; k < 8; k++) begin
      drive_wr(1'b1, 32'(32'h800 + k), 2'd3, 8'(k), 1'b1);
      tick();
    end
    drive_wr(1'b0, 32'h0, 2'd0, 8'h0, 1'b0);
    check("prerst_fill", fill_cnt, 7);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("mrst_fill", fill_cnt, 0);
    check("mrst_valid", rd_valid, 0);
    check("mrst_word", rd_word(), 0);
    check("mrst_empty", fifo_empty, 1);
    check("mrst_full", fifo_full, 0);
    check("mrst_afull", fifo_afull, 0);
    rd_ready = 1'b1;
    drive_wr(1'b1, 32'hA5, 2'd1, 8'h5A, 1'b1); tick();
    drive_wr(1'b0, 32'h0, 2'd0, 8'h0, 1'b0);
    check("post_rst_lat", rd_valid, 0);
    tick();
    check("post_rst_valid", rd_valid, 1);
    check("post_rst_word", rd_word(), {1'b1, 8'h5A, 2'd1, 32'hA5});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
